// File: rtl/type_buffer.sv
// Keyboard-side writer of the typed-text array shown by the VGA text renderer.
// The typed array is exported as `typed` because `type` is a reserved word.
// Optional backspace editing is enabled by defining TYPE_BUFFER_BACKSPACE_EN.
module type_buffer #(
    parameter int MAX_LEN    = 25,
    parameter int CW         = 5,
    parameter int WORD_CHARS = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       key_valid,
    input  logic [4:0]                 key_code,
    input  logic [WORD_CHARS*CW-1:0]   word,
    input  logic [4:0]                 word_len,
    output logic                       key_ready,
    output logic [MAX_LEN*CW-1:0]      typed,
    output logic [4:0]                 len,
    output logic [5:0]                 correct,
    output logic [5:0]                 tot,
    output logic                       overflow,
    output logic                       word_done,
    output logic                       word_ok
);

`ifdef TYPE_BUFFER_BACKSPACE_EN
    localparam bit BS_EN = 1'b1;
`else
    localparam bit BS_EN = 1'b0;
`endif

    localparam logic [4:0] LEN_FULL   = 5'(MAX_LEN);
    localparam logic [4:0] CODE_SPACE = 5'd27;
    localparam logic [4:0] CODE_BS    = 5'd28;

    typedef enum logic [1:0] {IDLE, TYPE, CHECK, COMMIT} state_t;

    state_t        state;
    logic [CW-1:0] buf_q [MAX_LEN];
    logic [5:0]    correct_c;
    logic          match_c;
    logic          run;
    logic          is_letter;

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign typed[g*CW +: CW] = buf_q[g];
    end

    assign tot       = {1'b0, len};
    assign is_letter = (key_code >= 5'd1) && (key_code <= 5'd26);

    // NOTE: blocking assignments are correct here; this is combinational
    // scratch logic, and every variable gets a default first to avoid latches.
    always_comb begin
        correct_c = '0;
        run       = 1'b1;
        for (int i = 0; i < WORD_CHARS; i++) begin
            if (run && (i < int'(len)) && (buf_q[i] == word[i*CW +: CW]))
                correct_c = correct_c + 6'd1;
            else
                run = 1'b0;
        end
    end

    // A full prefix match of exactly word_len chars is a correct word.
    assign match_c = (len == word_len) && (correct_c == {1'b0, len});

    // NOTE: the buffer is a small register file, not a RAM, so it is reset
    // with everything else; this keeps the renderer's view blank after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            key_ready <= 1'b1;
            len       <= '0;
            correct   <= '0;
            overflow  <= 1'b0;
            word_done <= 1'b0;
            word_ok   <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
        end else begin
            overflow  <= 1'b0;
            word_done <= 1'b0;
            correct   <= correct_c;
            unique case (state)
                IDLE, TYPE: begin
                    if (key_valid) begin
                        if (is_letter) begin
                            if (len < LEN_FULL) begin
                                buf_q[len] <= key_code;
                                len        <= len + 5'd1;
                                state      <= TYPE;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else if (key_code == CODE_SPACE && len != 5'd0) begin
                            state     <= CHECK;
                            key_ready <= 1'b0;
                        end else if (BS_EN && key_code == CODE_BS && len != 5'd0) begin
                            buf_q[len - 5'd1] <= '0;
                            len               <= len - 5'd1;
                            if (len == 5'd1) state <= IDLE;
                        end
                    end
                end
                CHECK: begin
                    // word_done rises as COMMIT begins: two edges after the space.
                    state     <= COMMIT;
                    word_done <= 1'b1;
                    word_ok   <= match_c;
                end
                COMMIT: begin
                    state     <= IDLE;
                    key_ready <= 1'b1;
                    len       <= '0;
                    correct   <= '0;
                    for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_type_buffer.sv
// Directed, table-driven bench for type_buffer; honours TYPE_BUFFER_BACKSPACE_EN.
module tb_type_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_valid = 1'b0;
    logic [4:0]   key_code = '0;
    logic [74:0]  word = '0;
    logic [4:0]   word_len = '0;
    logic         key_ready;
    logic [124:0] typed;
    logic [4:0]   len;
    logic [5:0]   correct;
    logic [5:0]   tot;
    logic         overflow;
    logic         word_done;
    logic         word_ok;

    int n_pass = 0;
    int n_total = 0;
    int done_cnt = 0;
    logic ovf_seen;

    type_buffer dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .word(word), .word_len(word_len), .key_ready(key_ready), .typed(typed),
        .len(len), .correct(correct), .tot(tot), .overflow(overflow),
        .word_done(word_done), .word_ok(word_ok)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (word_done) done_cnt++;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish (got running, want finished)");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic set_word(input logic [4:0] c0, input logic [4:0] c1, input logic [4:0] c2);
        word = '0;
        word[4:0] = c0;
        word[9:5] = c1;
        word[14:10] = c2;
        word_len = 5'd3;
    endtask

    // One-cycle key strobe; returns after one extra cycle so correct has settled.
    task automatic send_key(input logic [4:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(posedge clk); #1;
        ovf_seen  = overflow;
        key_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_commit(input logic exp_ok);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 5'd27;
        @(posedge clk); #1;
        key_valid = 1'b0;
        check("ready_in_check", key_ready, 1'b0);
        check("done_early", word_done, 1'b0);
        @(posedge clk); #1;
        check("word_done", word_done, 1'b1);
        check("word_ok", word_ok, exp_ok);
        @(posedge clk); #1;
        check("done_drop", word_done, 1'b0);
        check("len_clear", len, 5'd0);
        check("type_clear", typed, 125'd0);
        check("correct_clear", correct, 6'd0);
        check("ready_after", key_ready, 1'b1);
        check("word_ok_held", word_ok, exp_ok);
    endtask

    typedef struct {
        logic [4:0]  code;
        logic [4:0]  exp_len;
        logic [5:0]  exp_correct;
        logic [14:0] exp_lo;
        logic        exp_ok;
    } vec_t;

    vec_t vecs [8];
    logic [124:0] exp_full;
    int done_before;

    initial begin
        vecs[0] = '{5'd3,  5'd1, 6'd1, 15'd3,                 1'b0};
        vecs[1] = '{5'd1,  5'd2, 6'd2, {5'd0, 5'd1, 5'd3},    1'b0};
        vecs[2] = '{5'd20, 5'd3, 6'd3, {5'd20, 5'd1, 5'd3},   1'b0};
        vecs[3] = '{5'd27, 5'd0, 6'd0, 15'd0,                 1'b1};
        vecs[4] = '{5'd3,  5'd1, 6'd1, 15'd3,                 1'b0};
        vecs[5] = '{5'd1,  5'd2, 6'd2, {5'd0, 5'd1, 5'd3},    1'b0};
        vecs[6] = '{5'd2,  5'd3, 6'd2, {5'd2, 5'd1, 5'd3},    1'b0};
        vecs[7] = '{5'd27, 5'd0, 6'd0, 15'd0,                 1'b0};

        set_word(5'd3, 5'd1, 5'd20);
        repeat (3) @(posedge clk);
        #1;
        check("rst_type", typed, 125'd0);
        check("rst_len", len, 5'd0);
        check("rst_correct", correct, 6'd0);
        check("rst_tot", tot, 6'd0);
        check("rst_ready", key_ready, 1'b1);
        check("rst_word_ok", word_ok, 1'b0);
        @(negedge clk) rst = 1'b1;

        // Space on an empty buffer is ignored.
        send_key(5'd27);
        check("space_empty_len", len, 5'd0);
        check("space_empty_ready", key_ready, 1'b1);
        check("space_empty_done", done_cnt, 0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].code == 5'd27) begin
                do_commit(vecs[i].exp_ok);
            end else begin
                send_key(vecs[i].code);
                check("vec_len", len, vecs[i].exp_len);
                check("vec_tot", tot, {1'b0, vecs[i].exp_len});
                check("vec_correct", correct, vecs[i].exp_correct);
                check("vec_type", typed[14:0], vecs[i].exp_lo);
            end
        end

        // Fill to capacity, then overflow.
        exp_full = '0;
        for (int i = 0; i < 25; i++) begin
            send_key(5'd5);
            exp_full[i*5 +: 5] = 5'd5;
        end
        check("full_len", len, 5'd25);
        check("full_type", typed, exp_full);
        check("full_correct", correct, 6'd0);
        check("full_ovf_none", ovf_seen, 1'b0);
        send_key(5'd5);
        check("ovf_pulse", ovf_seen, 1'b1);
        check("ovf_drop", overflow, 1'b0);
        check("ovf_len", len, 5'd25);
        check("ovf_type", typed, exp_full);
        do_commit(1'b0);

        // Target word change mid-word recomputes correct only.
        send_key(5'd3);
        send_key(5'd1);
        check("pre_change_correct", correct, 6'd2);
        @(negedge clk) set_word(5'd4, 5'd15, 5'd7);
        @(posedge clk); #1;
        check("change_correct", correct, 6'd0);
        check("change_len", len, 5'd2);
        @(negedge clk) set_word(5'd3, 5'd1, 5'd20);
        do_commit(1'b0);

        // Key strobed during CHECK is dropped, not queued.
        send_key(5'd3);
        send_key(5'd1);
        send_key(5'd20);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 5'd27;
        @(posedge clk); #1;
        key_code  = 5'd5;
        @(posedge clk); #1;
        key_valid = 1'b0;
        check("drop_done", word_done, 1'b1);
        check("drop_ok", word_ok, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("drop_len", len, 5'd0);
        check("drop_type", typed, 125'd0);

        // Backspace.
        send_key(5'd3);
        send_key(5'd1);
        send_key(5'd28);
`ifdef TYPE_BUFFER_BACKSPACE_EN
        check("bs_len", len, 5'd1);
        check("bs_slot", typed[9:5], 5'd0);
        check("bs_correct", correct, 6'd1);
`else
        check("bs_len", len, 5'd2);
        check("bs_slot", typed[9:5], 5'd1);
        check("bs_correct", correct, 6'd2);
`endif
        do_commit(1'b0);

        // Reset mid-word: immediate clear, no word_done.
        send_key(5'd3);
        send_key(5'd1);
        done_before = done_cnt;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_len", len, 5'd0);
        check("mid_rst_type", typed, 125'd0);
        check("mid_rst_correct", correct, 6'd0);
        check("mid_rst_tot", tot, 6'd0);
        check("mid_rst_ready", key_ready, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_cnt, done_before);
        check("mid_rst_len_after", len, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
